// File: rtl/counter_snapshot_buffer_if.sv
// rtl/counter_snapshot_buffer_if.sv - record read port of the counter snapshot buffer
interface counter_snapshot_buffer_if #(
   parameter int WIDTH = 4
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH+1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/counter_snapshot_buffer.sv
// rtl/counter_snapshot_buffer.sv - tags counter changes (increment/wrap/discontinuity)
// and queues {disc, wrap, value} records in a first-word-fall-through FIFO.
module counter_snapshot_buffer #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 8,
   parameter int WRAP_W = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [WIDTH-1:0]           counter_in,
   counter_snapshot_buffer_if.master  out_if,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic [WRAP_W-1:0]          wrap_count,
   output logic                       overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] prev_inc;
   logic [WIDTH+1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   logic change;
   logic push;
   logic pop;
   logic full;
   logic do_write;
   logic is_wrap;
   logic is_disc;

   assign prev_inc = prev + 1'b1;
   assign change   = (counter_in != prev);
   assign push     = change && enable;
   assign is_wrap  = (prev == {WIDTH{1'b1}}) && (counter_in == '0);
   assign is_disc  = (counter_in != prev_inc) && !is_wrap;

   assign full     = (fill_level == FULL_LEVEL);
   assign pop      = out_if.out_valid && out_if.out_ready;
   // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
   assign do_write = push && (!full || pop);

   assign out_if.out_valid = (fill_level != '0);
   assign out_if.out_data  = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (!reset && do_write) begin
         mem[wr_ptr] <= {is_disc, is_wrap, counter_in};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         wrap_count <= '0;
         overflow   <= 1'b0;
      end else begin
         prev <= counter_in;
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_write, pop})
            2'b10:   fill_level <= fill_level + 1'b1;
            2'b01:   fill_level <= fill_level - 1'b1;
            default: fill_level <= fill_level;
         endcase
         // Wraps are counted even when the record itself is dropped.
         if (push && is_wrap && (wrap_count != {WRAP_W{1'b1}})) begin
            wrap_count <= wrap_count + 1'b1;
         end
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_counter_snapshot_buffer.sv
// tb/tb_counter_snapshot_buffer.sv - bench for counter_snapshot_buffer against a queue model
module tb_counter_snapshot_buffer;
   localparam int DEPTH = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] counter_in;
   logic       out_ready;
   logic [3:0] fill_level;
   logic [7:0] wrap_count;
   logic       overflow;

   int errors = 0;
   int checks = 0;

   int q[$];
   int m_prev = 0;
   int m_wc   = 0;
   bit m_ovf  = 0;

   counter_snapshot_buffer_if #(.WIDTH(4)) out_if ();
   assign out_if.out_ready = out_ready;

   counter_snapshot_buffer #(.WIDTH(4), .DEPTH(DEPTH), .WRAP_W(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .counter_in (counter_in),
      .out_if     (out_if),
      .fill_level (fill_level),
      .wrap_count (wrap_count),
      .overflow   (overflow)
   );

   always #5 clock = ~clock;

   // Drive one cycle of inputs, advance the reference model across the edge, sample 1 time unit later.
   task automatic step(input bit rst, input bit en, input int cin, input bit rdy);
      bit w, d, ch, pp;
      int rec;
      reset = rst; enable = en; counter_in = 4'(cin); out_ready = rdy;
      @(posedge clock);
      if (rst) begin
         q.delete(); m_prev = 0; m_wc = 0; m_ovf = 0;
      end else begin
         ch  = (cin != m_prev);
         w   = (m_prev == 15) && (cin == 0);
         d   = (cin != ((m_prev + 1) % 16)) && !w;
         rec = cin + (w ? 16 : 0) + (d ? 32 : 0);
         pp  = (q.size() > 0) && rdy;
         if (pp) void'(q.pop_front());
         if (ch && en) begin
            if (w && m_wc < 255) m_wc++;
            if (q.size() < DEPTH) q.push_back(rec);
            else m_ovf = 1;
         end
         m_prev = cin;
      end
      #1;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_if.out_valid); end
      checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
      checks++; if (wrap_count !== 8'd0) begin errors++; $display("FAIL reset_wrap: got %0d want 0", wrap_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
   endtask

   task automatic test_increment();
      step(1, 1, 0, 1);
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, i, 1);
         checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 6'(i)) begin
            errors++; $display("FAIL inc_record%0d: got v=%0b d=%02h want v=1 d=%02h", i, out_if.out_valid, out_if.out_data, i);
         end
         checks++; if (fill_level > 4'd1) begin errors++; $display("FAIL inc_fill%0d: got %0d want <=1", i, fill_level); end
      end
   endtask

   task automatic test_wrap();
      step(1, 1, 0, 1);
      for (int i = 1; i <= 16; i++) begin
         step(0, 1, i % 16, 1);
         checks++; if (out_if.out_data[5] !== 1'b0) begin errors++; $display("FAIL wrap_nodisc%0d: got %02h want disc=0", i, out_if.out_data); end
      end
      checks++; if (out_if.out_data !== 6'h10) begin errors++; $display("FAIL wrap_record: got %02h want 10", out_if.out_data); end
      checks++; if (wrap_count !== 8'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1", wrap_count); end
   endtask

   task automatic test_overflow();
      step(1, 1, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         step(0, 1, i, 0);
         if (i == 8) begin
            checks++; if (fill_level !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full: got fill=%0d ovf=%0b want 8/0", fill_level, overflow); end
         end
         if (i == 9) begin
            checks++; if (overflow !== 1'b1 || fill_level !== 4'd8) begin errors++; $display("FAIL ovf_set: got fill=%0d ovf=%0b want 8/1", fill_level, overflow); end
         end
      end
      for (int k = 1; k <= 8; k++) begin
         checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 6'(k)) begin
            errors++; $display("FAIL ovf_drain%0d: got v=%0b d=%02h want %02h", k, out_if.out_valid, out_if.out_data, k);
         end
         step(0, 1, 10, 1);
      end
      checks++; if (out_if.out_valid !== 1'b0 || fill_level !== 4'd0 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_empty: got v=%0b fill=%0d ovf=%0b want 0/0/1", out_if.out_valid, fill_level, overflow);
      end
   endtask

   task automatic test_full_push_pop();
      step(1, 1, 0, 0);
      for (int i = 1; i <= 8; i++) step(0, 1, i, 0);
      step(0, 1, 9, 1);
      checks++; if (fill_level !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_level: got fill=%0d ovf=%0b want 8/0", fill_level, overflow); end
      for (int k = 2; k <= 9; k++) begin
         checks++; if (out_if.out_data !== 6'(k)) begin errors++; $display("FAIL fpp_drain%0d: got %02h want %02h", k, out_if.out_data, k); end
         step(0, 1, 9, 1);
      end
   endtask

   task automatic test_discontinuity();
      step(1, 1, 0, 1);
      for (int i = 1; i <= 5; i++) step(0, 1, i, 1);
      step(0, 1, 0, 1);
      checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 6'h20) begin errors++; $display("FAIL disc_record: got v=%0b d=%02h want 20", out_if.out_valid, out_if.out_data); end
      checks++; if (wrap_count !== 8'd0) begin errors++; $display("FAIL disc_wrap: got %0d want 0", wrap_count); end
      step(0, 1, 0, 1);
      step(0, 1, 5, 1);
      checks++; if (out_if.out_data !== 6'h25) begin errors++; $display("FAIL disc_jump: got %02h want 25", out_if.out_data); end
      step(0, 1, 5, 1);
      step(0, 0, 0, 1);
      checks++; if (out_if.out_valid !== 1'b0 || fill_level !== 4'd0) begin errors++; $display("FAIL disc_disabled: got v=%0b fill=%0d want 0/0", out_if.out_valid, fill_level); end
      step(0, 1, 1, 1);
      checks++; if (out_if.out_data !== 6'h01) begin errors++; $display("FAIL disc_prev: got %02h want 01", out_if.out_data); end
   endtask

   task automatic test_reset_midburst();
      step(1, 1, 0, 1);
      for (int i = 1; i <= 16; i++) step(0, 1, i % 16, 1);
      for (int i = 1; i <= 9; i++) step(0, 1, i, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 9, 1);
      checks++; if (fill_level !== 4'd5 || overflow !== 1'b1 || wrap_count !== 8'd1) begin
         errors++; $display("FAIL mid_pre: got fill=%0d ovf=%0b wc=%0d want 5/1/1", fill_level, overflow, wrap_count);
      end
      step(1, 1, 3, 1);
      checks++; if (out_if.out_valid !== 1'b0 || fill_level !== 4'd0 || overflow !== 1'b0 || wrap_count !== 8'd0) begin
         errors++; $display("FAIL mid_reset: got v=%0b fill=%0d ovf=%0b wc=%0d want 0/0/0/0", out_if.out_valid, fill_level, overflow, wrap_count);
      end
      step(0, 1, 0, 1);
      step(0, 1, 1, 1);
      checks++; if (out_if.out_data !== 6'h01) begin errors++; $display("FAIL mid_after: got %02h want 01", out_if.out_data); end
   endtask

   task automatic test_random();
      int ctr = 0;
      int r;
      step(1, 1, 0, 0);
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6) ctr = (ctr + 1) % 16;
         else if (r == 8) ctr = $urandom_range(0, 15);
         else if (r == 9) ctr = 0;
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), ctr, ($urandom_range(0, 2) == 0));
         checks++; if (out_if.out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %0b want %0b", n, out_if.out_valid, q.size() > 0); end
         if (q.size() > 0) begin
            checks++; if (out_if.out_data !== 6'(q[0])) begin errors++; $display("FAIL rnd_data@%0d: got %02h want %02h", n, out_if.out_data, q[0]); end
         end
         checks++; if (fill_level !== 4'(q.size())) begin errors++; $display("FAIL rnd_fill@%0d: got %0d want %0d", n, fill_level, q.size()); end
         checks++; if (wrap_count !== 8'(m_wc)) begin errors++; $display("FAIL rnd_wrap@%0d: got %0d want %0d", n, wrap_count, m_wc); end
         checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", n, overflow, m_ovf); end
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; counter_in = 4'd0; out_ready = 1'b0;
      test_reset();
      test_increment();
      test_wrap();
      test_overflow();
      test_full_push_pop();
      test_discontinuity();
      test_reset_midburst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/counter_snapshot_buffer.md
Name: counter_snapshot_buffer

Overview:
- Downstream consumer of the 4-bit free-running counter's output.
- Watches the counter value every cycle and detects each change.
- Tags each change as a normal increment, a wrap (max->0) or a discontinuity (any other jump, e.g. counter reset).
- Queues {tag, value} records in a small FIFO with a valid/ready read port for a monitor or logger stage.

Parameters:
- WIDTH, 4: width of the counter value consumed.
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- WRAP_W, 8: width of the saturating wrap-event counter.

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  capture enable, tied to the same enable that drives the counter.
- counter_in  input  WIDTH  counter value being monitored.
- out_ready  input  1  consumer accepts the head record this cycle.
- out_valid  output  1  FIFO non-empty; out_data is valid.
- out_data  output  WIDTH+2  head record {disc, wrap, value[WIDTH-1:0]}.
- fill_level  output  log2(DEPTH)+1  number of stored records, 0..DEPTH.
- wrap_count  output  WRAP_W  wrap events seen, saturating at all-ones.
- overflow  output  1  sticky: a record was dropped because the FIFO was full.

Behaviour:
- Reset values (sync, next edge with reset=1):
  - out_valid=0, fill_level=0, wrap_count=0, overflow=0.
  - Internal prev register=0, read/write pointers=0.
  - out_data is don't-care while out_valid=0.
  - Reset has priority over every other event in the same cycle, including a mid-burst pop or push. FIFO contents are discarded.
- prev register loads counter_in on every non-reset edge, regardless of enable.
- Change detect: change = (counter_in != prev).
- Push condition: change && enable.
- Record classification (comparison against prev), with MAX = 2^WIDTH-1:
  - wrap=1 iff prev==MAX and counter_in==0.
  - disc=1 iff counter_in != prev+1 (mod 2^WIDTH) and wrap==0.
  - Normal increment: wrap=0, disc=0.
  - wrap and disc are never both 1.
- wrap_count increments by 1 on every pushed record with wrap=1, including records dropped for full. It holds at all-ones.
- Pop: occurs when out_valid && out_ready.
- Full push: if fill_level==DEPTH and push with no pop:
  - record dropped; contents and pointers unchanged;
  - overflow set to 1 and stays 1 until reset.
- Full push and pop in the same cycle: both accepted; fill_level unchanged.
- Empty FIFO with push: the record becomes visible with out_valid=1 on the cycle after the push edge (1-cycle latency). out_ready has no effect while empty.
- Read path is first-word-fall-through: out_data always reflects the head entry, registered.
- fill_level updates on the same edge as the push/pop; +1, -1, or unchanged for push+pop.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Counter held (enable=0, value constant): no change, no push.
- Counter reset to 0 from value v (v != MAX): one record {disc=1, wrap=0, 0}, provided enable=1.

Test Plan:
1. Reset, enable=1, counter_in steps 0->1->2->3 on consecutive cycles, out_ready=1 -> three records 0x01, 0x02, 0x03 (disc=0, wrap=0), each out_valid one cycle after its change; fill_level never exceeds 1.
2. counter_in runs 0x0..0xF->0x0 with out_ready=1 -> last record {0,1,0x0} = 0x10; wrap_count=1; no disc records.
3. out_ready=0, counter stepping 1..10 -> first 8 records stored, fill_level=8, overflow=1 after the 9th change; raising out_ready drains 0x01..0x08 in order.
4. FIFO full (fill_level=8), out_ready=1 and a new change in the same cycle -> fill_level stays 8, overflow stays 0 if previously 0, new record lands at the tail.
5. counter_in 5->0 (counter reset) with enable=1 -> record {disc=1, wrap=0, 0} = 0x20; wrap_count unchanged. Same jump with enable=0 -> no record; prev still updates to 0.
6. Assert reset while fill_level=5 and out_ready=1 -> next cycle out_valid=0, fill_level=0, overflow=0, wrap_count=0; a following 0->1 step produces 0x01.
